// File: rtl/spi_baud_if.sv
// Control inputs and SCLK/strobe outputs shared by the baud generator and its neighbours.
interface spi_baud_if #(
  parameter int unsigned CNT_W = 12
);
  logic [1:0]       spi_mode;
  logic             spiswai;
  logic [2:0]       sppr;
  logic [2:0]       spr;
  logic             cpol;
  logic             ss;
  logic             sclk;
  logic             flag_low;
  logic             flag_high;
  logic             flags_low;
  logic             flags_high;
  logic [CNT_W-1:0] baud_rate_divisor;
  logic             frame_done;

  modport master (
    output spi_mode, spiswai, sppr, spr, cpol, ss,
    input  sclk, flag_low, flag_high, flags_low, flags_high, baud_rate_divisor, frame_done
  );

  modport slave (
    input  spi_mode, spiswai, sppr, spr, cpol, ss,
    output sclk, flag_low, flag_high, flags_low, flags_high, baud_rate_divisor, frame_done
  );
endinterface

// File: rtl/spi_baud_generator.sv
// SPI baud generator: divides PCLK into SCLK, emits exact and early edge strobes,
// and pulses frame_done after each 2*FRAME_BITS SCLK edges.
module spi_baud_generator #(
  parameter int unsigned FRAME_BITS = 8,
  parameter int unsigned CNT_W      = 12
) (
  input  logic PCLK,
  input  logic PRESETn,
  spi_baud_if.slave bus
);

  localparam int unsigned EDGE_W = $clog2(2 * FRAME_BITS) + 1;
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * FRAME_BITS - 1);

  logic [CNT_W-1:0]  div_c;
  logic [CNT_W-1:0]  half_c;
  logic [CNT_W-1:0]  half_m1_c;
  logic [CNT_W-1:0]  early_c;
  logic              active_c;
  logic              run_c;
  logic              tick_c;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              sclk_q, sclk_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              done_q, done_d;

  // Divisor, half period and compare points; early point collapses onto the exact one at divisor 2.
  always_comb begin
    div_c     = (CNT_W'(bus.sppr) + CNT_W'(1)) << (4'(bus.spr) + 4'd1);
    half_c    = div_c >> 1;
    half_m1_c = half_c - CNT_W'(1);
    early_c   = (half_c >= CNT_W'(2)) ? (half_c - CNT_W'(2)) : half_m1_c;
  end

  // Transfer is live when selected and the mode does not freeze SCLK.
  always_comb begin
    active_c = !bus.ss && ((bus.spi_mode == 2'b00) ||
                           ((bus.spi_mode == 2'b01) && !bus.spiswai));
    run_c    = active_c && PRESETn;
    tick_c   = (count_q >= half_m1_c);
  end

  // Next-state: idle parks SCLK at cpol, otherwise count to half period and toggle.
  always_comb begin
    count_d = count_q;
    sclk_d  = sclk_q;
    edge_d  = edge_q;
    done_d  = 1'b0;
    if (!active_c) begin
      sclk_d  = bus.cpol;
      count_d = '0;
      edge_d  = '0;
    end else if (tick_c) begin
      sclk_d  = !sclk_q;
      count_d = '0;
      if (edge_q == EDGE_LAST) begin
        edge_d = '0;
        done_d = 1'b1;
      end else begin
        edge_d = edge_q + EDGE_W'(1);
      end
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // State registers; SCLK resets to the idle level selected by cpol.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count_q <= '0;
      sclk_q  <= bus.cpol;
      edge_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sclk_q  <= sclk_d;
      edge_q  <= edge_d;
      done_q  <= done_d;
    end
  end

  // Outputs: strobes decode registered state and drop the moment the transfer goes idle.
  always_comb begin
    bus.sclk              = sclk_q;
    bus.frame_done        = done_q;
    bus.baud_rate_divisor = div_c;
    bus.flag_low          = run_c && (count_q == half_m1_c) && !sclk_q;
    bus.flag_high         = run_c && (count_q == half_m1_c) &&  sclk_q;
    bus.flags_low         = run_c && (count_q == early_c)   && !sclk_q;
    bus.flags_high        = run_c && (count_q == early_c)   &&  sclk_q;
  end

endmodule

// File: tb/tb_spi_baud_generator.sv
// Self-checking bench for spi_baud_generator: timestamp-based reference model
// compared every cycle, plus directed literal checks and randomized traffic.
module tb_spi_baud_generator;

  localparam int unsigned CNT_W      = 12;
  localparam int unsigned FRAME_BITS = 8;
  localparam int          EDGES      = 2 * FRAME_BITS;

  logic PCLK = 1'b0;
  logic PRESETn;

  spi_baud_if #(.CNT_W(CNT_W)) bif();

  spi_baud_generator #(.FRAME_BITS(FRAME_BITS), .CNT_W(CNT_W)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bif.slave)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  // Model: absolute cycle of the last SCLK edge, SCLK level, edges in the current frame.
  int   cyc      = 0;
  int   m_last   = 0;
  logic m_sclk   = 1'b0;
  int   m_edges  = 0;
  logic m_done   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare DUT against the model every falling edge, then advance the model to the next rising edge.
  always @(negedge PCLK) begin : cmp
    int   div;
    int   half;
    int   el;
    int   early;
    logic act;
    div   = (int'(bif.sppr) + 1) * (1 << (int'(bif.spr) + 1));
    half  = div / 2;
    early = (half >= 2) ? half - 2 : half - 1;
    act   = (bif.ss == 1'b0) &&
            ((bif.spi_mode == 2'd0) || ((bif.spi_mode == 2'd1) && !bif.spiswai));
    chk("divisor", 32'(bif.baud_rate_divisor), 32'(div));
    if (!PRESETn) begin
      m_sclk  = bif.cpol;
      m_last  = cyc + 1;
      m_edges = 0;
      m_done  = 1'b0;
      chk("rst_sclk", 32'(bif.sclk), 32'(m_sclk));
      chk("rst_flags", 32'({bif.flag_low, bif.flag_high, bif.flags_low, bif.flags_high}), 32'd0);
      chk("rst_done", 32'(bif.frame_done), 32'd0);
    end else begin
      el = cyc - m_last;
      chk("sclk",       32'(bif.sclk),       32'(m_sclk));
      chk("frame_done", 32'(bif.frame_done), 32'(m_done));
      chk("flag_low",   32'(bif.flag_low),   32'(act && (el == half - 1) && !m_sclk));
      chk("flag_high",  32'(bif.flag_high),  32'(act && (el == half - 1) &&  m_sclk));
      chk("flags_low",  32'(bif.flags_low),  32'(act && (el == early)    && !m_sclk));
      chk("flags_high", 32'(bif.flags_high), 32'(act && (el == early)    &&  m_sclk));
      if (!act) begin
        m_sclk  = bif.cpol;
        m_last  = cyc + 1;
        m_edges = 0;
        m_done  = 1'b0;
      end else if (el >= half - 1) begin
        m_sclk  = !m_sclk;
        m_last  = cyc + 1;
        m_done  = (m_edges == EDGES - 1);
        m_edges = (m_edges + 1) % EDGES;
      end else begin
        m_done  = 1'b0;
      end
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic wait_sclk_change(input int bound, output int n);
    logic s0;
    s0 = bif.sclk;
    n  = 0;
    while (bif.sclk == s0 && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_frame_done(input int bound, output int n);
    n = 0;
    while (bif.frame_done !== 1'b1 && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int n;
    int pulses;
    PRESETn      = 1'b0;
    bif.ss       = 1'b1;
    bif.spi_mode = 2'b00;
    bif.spiswai  = 1'b0;
    bif.sppr     = 3'd0;
    bif.spr      = 3'd0;
    bif.cpol     = 1'b0;
    tick(3);
    PRESETn = 1'b1;
    tick(1);
    chk("lit_div2", 32'(bif.baud_rate_divisor), 32'd2);
    chk("lit_idle_sclk0", 32'(bif.sclk), 32'd0);

    // Divisor 2: a frame is 16 toggles, one per PCLK.
    bif.ss = 1'b0;
    wait_frame_done(100, n);
    chk("lit_frame_div2", 32'(n), 32'd16);

    // Divisor 8, cpol=1: half period of 4 PCLK.
    bif.ss = 1'b1;
    tick(2);
    bif.sppr = 3'd1;
    bif.spr  = 3'd1;
    bif.cpol = 1'b1;
    tick(1);
    chk("lit_div8", 32'(bif.baud_rate_divisor), 32'd8);
    chk("lit_idle_sclk1", 32'(bif.sclk), 32'd1);
    bif.ss = 1'b0;
    wait_sclk_change(50, n);
    chk("lit_div8_fall", 32'(n), 32'd4);
    wait_sclk_change(50, n);
    chk("lit_div8_rise", 32'(n), 32'd4);

    // Maximum divisor: first edge after 1024 cycles with a single strobe before it.
    bif.ss   = 1'b1;
    bif.sppr = 3'd7;
    bif.spr  = 3'd7;
    bif.cpol = 1'b0;
    tick(2);
    chk("lit_div2048", 32'(bif.baud_rate_divisor), 32'd2048);
    bif.ss = 1'b0;
    n      = 0;
    pulses = 0;
    while (bif.sclk == 1'b0 && n < 3000) begin
      if (bif.flag_low || bif.flag_high) pulses++;
      tick(1);
      n++;
    end
    chk("lit_max_first_edge", 32'(n), 32'd1024);
    chk("lit_max_pulses", 32'(pulses), 32'd1);

    // Abort after 5 edges at divisor 4, then a full restart.
    bif.ss   = 1'b1;
    bif.sppr = 3'd1;
    bif.spr  = 3'd0;
    tick(2);
    bif.ss = 1'b0;
    tick(10);
    bif.ss = 1'b1;
    tick(1);
    chk("lit_abort_sclk", 32'(bif.sclk), 32'd0);
    tick(3);
    bif.ss = 1'b0;
    wait_frame_done(200, n);
    chk("lit_restart_frame", 32'(n), 32'd32);

    // WAIT mode with and without spiswai, then STOP.
    bif.ss       = 1'b1;
    tick(2);
    bif.spi_mode = 2'b01;
    bif.spiswai  = 1'b1;
    bif.ss       = 1'b0;
    tick(20);
    chk("lit_wait_hold", 32'(bif.sclk), 32'd0);
    bif.spiswai  = 1'b0;
    tick(20);
    bif.spi_mode = 2'b10;
    tick(10);
    chk("lit_stop_hold", 32'(bif.sclk), 32'd0);
    bif.spi_mode = 2'b00;
    bif.ss       = 1'b1;
    tick(2);

    // Divisor 16 -> 4 while count is 6: toggle on the next cycle, then period 4.
    bif.sppr = 3'd1;
    bif.spr  = 3'd2;
    tick(1);
    bif.ss = 1'b0;
    tick(6);
    chk("lit_chg_before", 32'(bif.sclk), 32'd0);
    bif.spr = 3'd0;
    tick(1);
    chk("lit_chg_toggle", 32'(bif.sclk), 32'd1);
    tick(1);
    chk("lit_chg_hold", 32'(bif.sclk), 32'd1);
    tick(1);
    chk("lit_chg_next", 32'(bif.sclk), 32'd0);

    // Randomized traffic, including mid-transfer resets.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 39) == 0)  bif.ss = ~bif.ss;
      if ($urandom_range(0, 99) == 0) begin
        bif.sppr = 3'($urandom_range(0, 3));
        bif.spr  = 3'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 59) == 0)  bif.spi_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0)  bif.spiswai  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 79) == 0)  bif.cpol     = ~bif.cpol;
      if ($urandom_range(0, 499) == 0) begin
        PRESETn = 1'b0;
        tick(2);
        PRESETn = 1'b1;
      end
      tick(1);
    end

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
